// File: rtl/alu_mc.sv
// Multi-cycle integer execute unit: RV32I/RV64I ALU ops in one cycle, M-extension
// multiply/divide via an iterative one-bit-per-cycle datapath, valid/ready on both sides.
module alu_mc #(
  parameter int XLEN   = 32,
  parameter bit MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] y_o,
  output logic            busy_o
);
  // state | meaning
  // IDLE  | waiting for an op, in_ready_o high
  // CALC  | one multiply/divide step per edge
  // FIX   | sign correction and half/quotient/remainder select
  // DONE  | result held until writeback drains it
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     y_q, y_d, hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d, divz_q, divz_d;

  logic                is_m_op, sgn_a, sgn_b, geq;
  logic [XLEN-1:0]     abs_a, abs_b, diff;
  logic [XLEN:0]       sum, rs;
  logic [2*XLEN-1:0]   prod;

  function automatic logic [XLEN-1:0] basic_res(input logic [4:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a << sh;
      5'd3:    return XLEN'($signed(a) < $signed(b));
      5'd4:    return XLEN'(a < b);
      5'd5:    return a ^ b;
      5'd6:    return a >> sh;
      5'd7:    return $signed(a) >>> sh;
      5'd8:    return a | b;
      5'd9:    return a & b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    divz_d  = divz_q;
    is_m_op = MULDIV && (op_i inside {[5'd10:5'd17]});
    // MULHSU: A signed, B unsigned; MUL's low half is sign-agnostic
    sgn_a   = a_i[XLEN-1] && (op_i inside {5'd11, 5'd12, 5'd14, 5'd16});
    sgn_b   = b_i[XLEN-1] && (op_i inside {5'd11, 5'd14, 5'd16});
    abs_a   = sgn_a ? -a_i : a_i;
    abs_b   = sgn_b ? -b_i : b_i;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rs      = {hi_q, lo_q[XLEN-1]};
    geq     = rs >= {1'b0, m_q};
    diff    = rs[XLEN-1:0] - m_q;
    prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    unique case (state_q)
      IDLE: if (in_valid_i) begin
        op_d = op_i;
        if (is_m_op) begin
          hi_d    = '0;
          lo_d    = (op_i >= 5'd14) ? abs_a : abs_b;
          m_d     = (op_i >= 5'd14) ? abs_b : abs_a;
          neg_d   = (op_i == 5'd16) ? sgn_a : (sgn_a ^ sgn_b);
          divz_d  = (b_i == '0);
          cnt_d   = CW'(XLEN);
          state_d = CALC;
        end else begin
          y_d     = basic_res(op_i, a_i, b_i);
          state_d = DONE;
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q >= 5'd14) begin
          hi_d = geq ? diff : rs[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], geq};
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        case (op_q)
          5'd10:               y_d = prod[XLEN-1:0];
          5'd11, 5'd12, 5'd13: y_d = prod[2*XLEN-1:XLEN];
          5'd14, 5'd15:        y_d = divz_q ? '1 : (neg_q ? -lo_q : lo_q);
          default:             y_d = neg_q ? -hi_q : hi_q;
        endcase
        state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
    endcase

    if (kill_i) begin
      state_d = IDLE;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign y_o         = y_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus randomized ops, checked every cycle
// against a latency/result model computed with plain arithmetic.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kill_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] y_o;
  logic        busy_o;

  logic        n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b0, n_busy;
  logic [4:0]  n_op = '0;
  logic [31:0] n_a = '0, n_b = '0, n_y;
  logic        n_kill = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .MULDIV(1'b1)) u_dut (
    .clk(clk), .reset(reset), .kill_i(kill_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .y_o(y_o), .busy_o(busy_o));

  alu_mc #(.XLEN(32), .MULDIV(1'b0)) u_nomd (
    .clk(clk), .reset(reset), .kill_i(n_kill), .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
    .op_i(n_op), .a_i(n_a), .b_i(n_b), .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
    .y_o(n_y), .busy_o(n_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return sa >>> b[4:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'd11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      5'd12: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      5'd13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Model: result and remaining latency per accepted op
  bit          m_busy = 0, m_valid = 0;
  logic [31:0] m_y = '0, m_res = '0;
  int          m_wait = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_y = '0; m_wait = 0;
    end else if (kill_i) begin
      m_busy = 0; m_valid = 0;
    end else if (!m_busy) begin
      if (in_valid_i) begin
        m_busy = 1;
        m_res  = ref_res(op_i, a_i, b_i);
        if (op_i >= 5'd10 && op_i <= 5'd17) m_wait = 33;
        else begin m_valid = 1; m_y = m_res; end
      end
    end else if (!m_valid) begin
      m_wait--;
      if (m_wait == 0) begin m_valid = 1; m_y = m_res; end
    end else if (out_ready_i) begin
      m_valid = 0; m_busy = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid_o, m_valid);
    chk("busy", busy_o, m_busy);
    chk("in_ready", in_ready_o, !m_busy);
    chk("y", y_o, m_y);
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int kill_at, input bit kill_drain,
                        output logic [31:0] y, output int lat);
    int n;
    y = '0;
    lat = -1;
    in_valid_i = 1; op_i = op; a_i = a; b_i = b;
    kill_i = (kill_at == 0);
    @(posedge clk); #1;
    in_valid_i = 0; kill_i = 0; op_i = 5'($urandom); a_i = $urandom; b_i = $urandom;
    if (kill_at == 0) return;
    n = 0;
    while (!out_valid_o && n < 60) begin
      kill_i = (kill_at == n + 1);
      @(posedge clk); #1;
      n++;
      if (kill_i) begin kill_i = 0; return; end
    end
    if (!out_valid_o) begin
      chk("result_timeout", out_valid_o, 1'b1);
      return;
    end
    y = y_o;
    lat = n;
    repeat (hold) @(posedge clk);
    #1;
    out_ready_i = 1; kill_i = kill_drain;
    @(posedge clk); #1;
    out_ready_i = 0; kill_i = 0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] y;
    int lat;

    @(negedge clk);
    chk("reset_valid", out_valid_o, 1'b0);
    chk("reset_y", y_o, 32'd0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_ready", in_ready_o, 1'b1);
    reset = 0;
    @(negedge clk);

    run_op(5'd0, 32'h7FFF_FFFF, 32'd1, 0, -1, 0, y, lat);
    chk("add_y", y, 32'h8000_0000);
    chk("add_lat", lat, 0);
    chk("ready_after_drain", in_ready_o, 1'b1);

    run_op(5'd7, 32'h8000_0000, 32'h1F, 5, -1, 0, y, lat);
    chk("sra_y", y, 32'hFFFF_FFFF);

    run_op(5'd11, 32'hFFFF_FFFF, 32'd2, 0, -1, 0, y, lat);
    chk("mulh_y", y, 32'hFFFF_FFFF);
    chk("mulh_lat", lat, 33);
    run_op(5'd13, 32'hFFFF_FFFF, 32'd2, 0, -1, 0, y, lat);
    chk("mulhu_y", y, 32'd1);

    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0, y, lat);
    chk("div_ovf", y, 32'h8000_0000);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0, y, lat);
    chk("rem_ovf", y, 32'd0);
    run_op(5'd15, 32'd7, 32'd0, 0, -1, 0, y, lat);
    chk("divu_z", y, 32'hFFFF_FFFF);
    run_op(5'd17, 32'd7, 32'd0, 0, -1, 0, y, lat);
    chk("remu_z", y, 32'd7);
    run_op(5'd14, 32'hFFFF_FFF9, 32'd2, 0, -1, 0, y, lat);
    chk("div_neg", y, 32'hFFFF_FFFD);
    run_op(5'd16, 32'hFFFF_FFF9, 32'd2, 0, -1, 0, y, lat);
    chk("rem_neg", y, 32'hFFFF_FFFF);

    run_op(5'd15, 32'd100, 32'd7, 0, 10, 0, y, lat);
    chk("kill_busy", busy_o, 1'b0);
    chk("kill_valid", out_valid_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_op(5'd0, 32'd2, 32'd3, 0, -1, 0, y, lat);
    chk("add_after_kill", y, 32'd5);

    // Async reset in the middle of a multiply
    in_valid_i = 1; op_i = 5'd10; a_i = 32'd9; b_i = 32'd9;
    @(posedge clk); #1;
    in_valid_i = 0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1;
    #1;
    chk("rst_mid_valid", out_valid_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_y", y_o, 32'd0);
    chk("rst_mid_ready", in_ready_o, 1'b1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // MULDIV=0 instance
    n_in_valid = 1; n_op = 5'd0; n_a = 32'd3; n_b = 32'd4;
    @(posedge clk); #1;
    n_in_valid = 0;
    chk("nomd_add", n_y, 32'd7);
    n_out_ready = 1;
    @(posedge clk); #1;
    n_out_ready = 0;
    n_in_valid = 1; n_op = 5'd10;
    @(posedge clk); #1;
    n_in_valid = 0;
    chk("nomd_mul_valid", n_out_valid, 1'b1);
    chk("nomd_mul_y", n_y, 32'd0);
    n_out_ready = 1;
    @(posedge clk); #1;
    n_out_ready = 0;
    chk("nomd_idle", n_busy, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      int kat;
      op  = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(0, 31));
      kat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 36) : -1;
      run_op(op, pick_operand(), pick_operand(), $urandom_range(0, 3), kat,
             ($urandom_range(0, 15) == 0), y, lat);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle integer execute unit for the Pillar core, replacing the stage-gated single-op ALU. It executes the full RV32I register/immediate arithmetic set plus the optional M-extension, using a valid/ready handshake on both sides instead of the `stage_i` strobe. Basic ops complete in one cycle. Multiply and divide run an iterative one-bit-per-cycle datapath. Decode drives the input side; writeback drains the output side.

## Interface
- `XLEN`, default 32: operand and result width; legal values 32 or 64.
- `MULDIV`, default 1: 1 enables M ops; 0 makes M ops complete as single-cycle ops with a result of 0.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `kill_i` input 1: synchronous abort of any in-flight or completed-but-undrained op.
- `in_valid_i` input 1: decode presents an op.
- `in_ready_o` output 1: unit can accept; high only in IDLE.
- `op_i` input 5: opcode.
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18–31 illegal.
- `a_i` input XLEN: operand A (rs1).
- `b_i` input XLEN: operand B (rs2 or sign-extended immediate).
- `out_valid_o` output 1: `y_o` holds a result.
- `out_ready_i` input 1: writeback consumes the result.
- `y_o` output XLEN: result, held stable while `out_valid_o` is high.
- `busy_o` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset enters IDLE with `out_valid_o`=0, `y_o`=0, `busy_o`=0, `in_ready_o`=1.
- Operand capture: an op is accepted on a rising edge with `in_valid_i` and `in_ready_o` both high. Operands and op are captured into internal registers; inputs are don't-care afterwards.
- Ops 0–9 and illegal ops: the result is computed and registered on the accepting edge, and the FSM goes IDLE→DONE. Illegal ops give `y_o`=0.
- Shifts: the shift amount is `b[log2(XLEN)-1:0]`. SRA fills with `a[XLEN-1]`.
- Compares: SLT/SLTU return 1 or 0, zero-extended.
- Add/sub: ADD and SUB wrap modulo 2^XLEN. No flags are produced.
- M ops, accepting edge: operands are latched as absolute values per signedness (MULHSU treats A as signed, B as unsigned), the result sign is recorded, the step counter is loaded with XLEN, and the FSM goes IDLE→CALC.
- M ops, CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge. The counter decrements; at 0 the FSM goes to FIX.
- M ops, FIX: negate per the recorded sign and select the low or high half (MUL/MULH*) or quotient/remainder, then go to DONE.
- Divide by zero: DIV and DIVU give all-ones; REM and REMU give A.
- Signed overflow: DIV with A=−2^(XLEN−1) and B=−1 gives A; REM in that case gives 0. No trap is raised.
- DONE: `out_valid_o`=1. On an edge with `out_ready_i`=1 the FSM goes to IDLE and `out_valid_o` drops.

## Timing
- Edge numbering: the accepting edge is edge 0.
- Basic/illegal ops: `out_valid_o` is high after edge 0 (latency 1 cycle).
- M ops: `out_valid_o` is high after edge XLEN+1 (34 cycles of latency at XLEN=32).
- Throughput: `in_ready_o` is low in DONE, so the next accept is earliest one edge after the drain edge. The best case is one basic op every 2 cycles.
- Backpressure: `y_o` and `out_valid_o` stay stable for as long as `out_ready_i` is low.
- `kill_i`=1 at an edge, from any state: the FSM goes to IDLE, `out_valid_o` goes to 0, and `y_o` keeps its last value.
  - `kill_i` takes priority over an accept in IDLE.
  - `kill_i` takes priority over a drain in DONE.
- `reset` asserted mid-CALC: outputs return to their reset values without waiting for a clock edge.
- Accept is evaluated only in IDLE, so there is no simultaneous accept and drain.

## Test plan
- Basic op: ADD with A=0x7FFFFFFF, B=1 → after edge 0, `y_o`=0x80000000 and `out_valid_o`=1; `in_ready_o`=1 one edge after drain.
- Backpressure: SRA with A=0x80000000, B=0x1F → `y_o`=0xFFFFFFFF, and `out_valid_o`/`y_o` stay stable while `out_ready_i` is held low for 5 cycles.
- Multiply: MULH with A=0xFFFFFFFF (−1), B=2 → `y_o`=0xFFFFFFFF exactly at edge 33; MULHU with the same operands → 0x00000001.
- Division corner cases: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
- Kill: DIVU accepted, `kill_i` pulsed at edge 10 → `busy_o`=0 after edge 10, no `out_valid_o`, and the next ADD 2+3 → 5.
- Reset and MULDIV=0: async `reset` asserted mid-CALC → outputs go to 0 immediately; with MULDIV=0, MUL 3×4 → `y_o`=0 after edge 0.
